score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//  Parametrised score keeper and multiplexed 7-segment driver for the Flappy Bird top level.
//  Holds the running score as packed BCD and keeps a session high score.
//  Game logic increments the score with single-cycle pulses.
//  Time-multiplexes NUM_DIGITS digits onto one common-anode display.
//  Uses BCD add-with-carry throughout, with no divide/modulo.
// PARAMETERS
//  NUM_DIGITS        4   displayed/stored BCD digits (2..8)
//  REFRESH_DIV_BITS  18  digit period = 2^REFRESH_DIV_BITS clocks (2.6 ms at 100 MHz)
//  BLANK_LEADING     1   1 = blank leading zeros (digit 0 always lit)
// PORTS
//  clock_100Mhz  in   1             system clock
//  reset         in   1             synchronous, active-high
//  score_inc     in   1             1-cycle pulse: add inc_amount to score
//  inc_amount    in   4             BCD step 0..9; values 10..15 treated as 9
//  score_clr     in   1             1-cycle pulse: score <= 0, re-arm new_high
//  show_high     in   1             level: 1 = display high score, 0 = current score
//  score_bcd     out  4*NUM_DIGITS  current score, digit k at [4k+3:4k], k=0 units
//  high_bcd      out  4*NUM_DIGITS  highest score since reset
//  new_high      out  1             1-cycle pulse, first time score exceeds high this game
//  saturated     out  1             score == all nines
//  Anode_Activate out NUM_DIGITS    active-low anodes, bit k drives digit k
//  LED_out       out  7             active-low cathodes {a,b,c,d,e,f,g}
// BEHAVIOUR
//  Reset (synchronous): all registers are cleared on the clock edge where reset=1.
//   - score_bcd = high_bcd = 0; new_high = 0; saturated = 0; new_high armed.
//   - refresh counter = 0; scan index = 0.
//   - Anode_Activate = all 1s; LED_out = 7'h7F.
//  Score update (registered; visible 1 cycle after the pulse):
//   - score_clr has priority over score_inc in the same cycle; the result is 0.
//   - Increment: BCD ripple add of inc_amount at digit 0, carry propagating upward.
//   - Saturation: if the true sum exceeds all nines, score = all nines.
//   - saturated = (score_bcd == all nines), registered together with score_bcd.
//  High score:
//   - Each cycle, if score_bcd > high_bcd (plain unsigned compare is valid on packed BCD),
//     then high_bcd <= score_bcd on the next edge.
//   - new_high pulses for 1 cycle, on the same edge as the high_bcd update, only if armed.
//     The pulse disarms new_high. score_clr or reset re-arms it.
//   - high_bcd is not affected by score_clr.
//  Display scan:
//   - REFRESH_DIV_BITS-bit free-running counter.
//   - On counter wrap (all ones -> 0), the scan index advances.
//   - The scan index wraps NUM_DIGITS-1 -> 0, and must be correct for non-power-of-2 NUM_DIGITS.
//   - Value source: show_high ? high_bcd : score_bcd, sampled live.
//   - Anode_Activate and LED_out are registered, 1 cycle after the index/value change.
//     Exactly one anode bit is low (bit = scan index).
//   - Segment encodings, 0..9: 0000001, 1001111, 0010010, 0000110, 1001100,
//     0100100, 0100000, 0001111, 0000000, 0000100. Illegal digit shows 0.
//   - Blanking: with BLANK_LEADING=1, digit k>0 shows 7'h7F when it and every higher digit are 0.
// TESTING
//  (sim uses REFRESH_DIV_BITS=2, NUM_DIGITS=4 unless noted)
//  1. Reset held 2 cycles -> Anode_Activate=4'b1111, LED_out=7'h7F, score_bcd=high_bcd=0.
//     Release reset -> 1st anode 4'b1110.
//  2. inc 9, then inc 3 -> score_bcd=16'h0012. inc 15 -> 16'h0021 (clamped to 9).
//     clr+inc in the same cycle -> 16'h0000.
//  3. NUM_DIGITS=2: 11 x inc 9 -> score 8'h99, saturated=1. Further inc 5 -> still 8'h99.
//  4. Game to 0x25 (new_high exactly once, on the 1st inc); clr; incs of 9 -> 09, 18, 27.
//     new_high pulses once when score=0x27, and high_bcd=0x27.
//  5. score 0x0042, show_high=0 -> anodes 1110, 1101, 1011, 0111, each 4 cycles.
//     LED_out = 0010010, 1001100, 7'h7F, 7'h7F.
//  6. show_high toggled mid-scan -> next registered LED_out reflects high_bcd.
//     reset asserted mid-scan -> next cycle all anodes off; score_bcd and high_bcd = 0.

Source files
------------

// File: rtl/score_display_ctrl_if.sv
// Game-logic side of the score/display controller: score commands in,
// score state and multiplexed 7-segment drive out.
interface score_display_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    score_inc;
    logic [3:0]              inc_amount;
    logic                    score_clr;
    logic                    show_high;
    logic [4*NUM_DIGITS-1:0] score_bcd;
    logic [4*NUM_DIGITS-1:0] high_bcd;
    logic                    new_high;
    logic                    saturated;
    logic [NUM_DIGITS-1:0]   Anode_Activate;
    logic [6:0]              LED_out;

    modport master (
        output score_inc, inc_amount, score_clr, show_high,
        input  score_bcd, high_bcd, new_high, saturated, Anode_Activate, LED_out
    );

    modport slave (
        input  score_inc, inc_amount, score_clr, show_high,
        output score_bcd, high_bcd, new_high, saturated, Anode_Activate, LED_out
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Packed-BCD score keeper with session high score and a time-multiplexed
// common-anode 7-segment driver; arithmetic is BCD add-with-carry only.
module score_display_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV_BITS = 18,
    parameter int BLANK_LEADING    = 1
) (
    input  logic                clock_100Mhz,
    input  logic                reset,
    score_display_ctrl_if.slave bus
);
    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [W-1:0]     ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF   = 7'h7F;

    logic [W-1:0]                score_q, score_d;
    logic [W-1:0]                high_q, high_d;
    logic                        saturated_q, saturated_d;
    logic                        new_high_q, new_high_d;
    logic                        armed_q, armed_d;
    logic [REFRESH_DIV_BITS-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0]       anode_q, anode_d;
    logic [6:0]                  led_q, led_d;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 7'b0000001;
            4'd1:    seg_encode = 7'b1001111;
            4'd2:    seg_encode = 7'b0010010;
            4'd3:    seg_encode = 7'b0000110;
            4'd4:    seg_encode = 7'b1001100;
            4'd5:    seg_encode = 7'b0100100;
            4'd6:    seg_encode = 7'b0100000;
            4'd7:    seg_encode = 7'b0001111;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0000100;
            default: seg_encode = 7'b0000001;
        endcase
    endfunction

    // BCD ripple add of the clamped step at the units digit.
    logic [3:0] inc_step;
    logic [4:0] digit_sum;
    logic       carry;
    logic [W-1:0] sum_bcd;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        inc_step  = (bus.inc_amount > 4'd9) ? 4'd9 : bus.inc_amount;
        carry     = 1'b0;
        digit_sum = '0;
        sum_bcd   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_sum = {1'b0, score_q[4*k +: 4]} + {1'b0, (k == 0) ? inc_step : 4'd0}
                      + {4'd0, carry};
            if (digit_sum > 5'd9) begin
                sum_bcd[4*k +: 4] = 4'(digit_sum - 5'd10);
                carry             = 1'b1;
            end else begin
                sum_bcd[4*k +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
    end

    always_comb begin
        score_d = score_q;
        if (bus.score_clr)
            score_d = '0;
        else if (bus.score_inc)
            score_d = carry ? ALL_NINES : sum_bcd;
        saturated_d = (score_d == ALL_NINES);

        high_d     = (score_q > high_q) ? score_q : high_q;
        new_high_d = (score_q > high_q) && armed_q;
        armed_d    = bus.score_clr ? 1'b1 : (new_high_d ? 1'b0 : armed_q);
    end

    // Display scan: index steps once per refresh-counter wrap.
    logic [W-1:0]          disp_value;
    logic [3:0]            disp_digit;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] blank_mask;

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (&refresh_cnt_q)
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

        disp_value = bus.show_high ? high_q : score_q;
        disp_digit = disp_value[4*idx_q +: 4];

        upper_zero = 1'b1;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero    = upper_zero && (disp_value[4*k +: 4] == 4'd0);
            blank_mask[k] = (BLANK_LEADING != 0) && (k != 0) && upper_zero;
        end

        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        led_d   = blank_mask[idx_q] ? SEG_OFF : seg_encode(disp_digit);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            score_q       <= '0;
            high_q        <= '0;
            saturated_q   <= 1'b0;
            new_high_q    <= 1'b0;
            armed_q       <= 1'b1;
            refresh_cnt_q <= '0;
            idx_q         <= '0;
            anode_q       <= '1;
            led_q         <= SEG_OFF;
        end else begin
            score_q       <= score_d;
            high_q        <= high_d;
            saturated_q   <= saturated_d;
            new_high_q    <= new_high_d;
            armed_q       <= armed_d;
            refresh_cnt_q <= refresh_cnt_d;
            idx_q         <= idx_d;
            anode_q       <= anode_d;
            led_q         <= led_d;
        end
    end

    assign bus.score_bcd      = score_q;
    assign bus.high_bcd       = high_q;
    assign bus.saturated      = saturated_q;
    assign bus.new_high       = new_high_q;
    assign bus.Anode_Activate = anode_q;
    assign bus.LED_out        = led_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: a 4-digit instance for most scenarios
// and a 2-digit instance for saturation.
module tb_score_display_ctrl;
    logic clk;
    logic reset;
    int   asserts;
    int   failures;
    int   nh_count;

    score_display_ctrl_if #(.NUM_DIGITS(4)) if4 ();
    score_display_ctrl_if #(.NUM_DIGITS(2)) if2 ();

    score_display_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV_BITS(2), .BLANK_LEADING(1)) dut4 (
        .clock_100Mhz (clk),
        .reset        (reset),
        .bus          (if4.slave)
    );

    score_display_ctrl #(.NUM_DIGITS(2), .REFRESH_DIV_BITS(2), .BLANK_LEADING(1)) dut2 (
        .clock_100Mhz (clk),
        .reset        (reset),
        .bus          (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial nh_count = 0;
    always @(posedge clk) if (if4.new_high === 1'b1) nh_count <= nh_count + 1;

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic pulse_inc(input logic [3:0] amt);
        @(negedge clk);
        if4.score_inc  = 1'b1;
        if4.inc_amount = amt;
        @(negedge clk);
        if4.score_inc  = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) if4.score_clr = 1'b1;
        @(negedge clk) if4.score_clr = 1'b0;
    endtask

    task automatic pulse_inc2(input logic [3:0] amt);
        @(negedge clk);
        if2.score_inc  = 1'b1;
        if2.inc_amount = amt;
        @(negedge clk);
        if2.score_inc  = 1'b0;
    endtask

    // Waits for the first cycle of a digit-0 period (anode 0111 -> 1110).
    task automatic wait_digit0_start();
        logic [3:0] prev;
        bit         found;
        prev  = if4.Anode_Activate;
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (prev == 4'b0111 && if4.Anode_Activate == 4'b1110) found = 1'b1;
            prev = if4.Anode_Activate;
        end
        asserts++;
        if (!found) begin
            failures++;
            $display("FAIL scan_align: got no 0111->1110 transition, expected one within 64 cycles");
        end
    endtask

    task automatic test_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        asserts++;
        if (if4.Anode_Activate !== 4'b1111) begin
            failures++; $display("FAIL reset_anode: got %b expected 1111", if4.Anode_Activate);
        end
        asserts++;
        if (if4.LED_out !== 7'h7F) begin
            failures++; $display("FAIL reset_led: got %b expected 1111111", if4.LED_out);
        end
        asserts++;
        if (if4.score_bcd !== 16'h0000 || if4.high_bcd !== 16'h0000) begin
            failures++; $display("FAIL reset_score: got %h/%h expected 0000/0000", if4.score_bcd, if4.high_bcd);
        end
        asserts++;
        if (if4.new_high !== 1'b0 || if4.saturated !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got %b/%b expected 0/0", if4.new_high, if4.saturated);
        end
        reset = 1'b0;
        @(negedge clk);
        asserts++;
        if (if4.Anode_Activate !== 4'b1110) begin
            failures++; $display("FAIL first_anode: got %b expected 1110", if4.Anode_Activate);
        end
        asserts++;
        if (if4.LED_out !== 7'b0000001) begin
            failures++; $display("FAIL first_led: got %b expected 0000001", if4.LED_out);
        end
    endtask

    task automatic test_increment();
        do_reset();
        pulse_inc(4'd9);
        asserts++;
        if (if4.score_bcd !== 16'h0009) begin
            failures++; $display("FAIL inc_9: got %h expected 0009", if4.score_bcd);
        end
        pulse_inc(4'd3);
        asserts++;
        if (if4.score_bcd !== 16'h0012) begin
            failures++; $display("FAIL inc_carry: got %h expected 0012", if4.score_bcd);
        end
        pulse_inc(4'd15);
        asserts++;
        if (if4.score_bcd !== 16'h0021) begin
            failures++; $display("FAIL inc_clamp: got %h expected 0021", if4.score_bcd);
        end
        @(negedge clk);
        if4.score_inc  = 1'b1;
        if4.score_clr  = 1'b1;
        if4.inc_amount = 4'd5;
        @(negedge clk);
        if4.score_inc  = 1'b0;
        if4.score_clr  = 1'b0;
        asserts++;
        if (if4.score_bcd !== 16'h0000) begin
            failures++; $display("FAIL clr_priority: got %h expected 0000", if4.score_bcd);
        end
        asserts++;
        if (if4.high_bcd !== 16'h0021) begin
            failures++; $display("FAIL high_kept: got %h expected 0021", if4.high_bcd);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) pulse_inc2(4'd9);
        asserts++;
        if (if2.score_bcd !== 8'h90 || if2.saturated !== 1'b0) begin
            failures++; $display("FAIL sat_pre: got %h/%b expected 90/0", if2.score_bcd, if2.saturated);
        end
        pulse_inc2(4'd9);
        asserts++;
        if (if2.score_bcd !== 8'h99 || if2.saturated !== 1'b1) begin
            failures++; $display("FAIL sat_reach: got %h/%b expected 99/1", if2.score_bcd, if2.saturated);
        end
        pulse_inc2(4'd5);
        asserts++;
        if (if2.score_bcd !== 8'h99 || if2.saturated !== 1'b1) begin
            failures++; $display("FAIL sat_hold: got %h/%b expected 99/1", if2.score_bcd, if2.saturated);
        end
    endtask

    task automatic test_new_high();
        int base;
        do_reset();
        base = nh_count;
        pulse_inc(4'd9);
        pulse_inc(4'd9);
        pulse_inc(4'd7);
        asserts++;
        if (if4.score_bcd !== 16'h0025) begin
            failures++; $display("FAIL game1_score: got %h expected 0025", if4.score_bcd);
        end
        @(negedge clk);
        @(negedge clk);
        asserts++;
        if (nh_count - base !== 1 || if4.high_bcd !== 16'h0025) begin
            failures++; $display("FAIL game1_high: got %0d pulses high %h expected 1 pulse high 0025", nh_count - base, if4.high_bcd);
        end
        pulse_clr();
        asserts++;
        if (if4.score_bcd !== 16'h0000 || if4.high_bcd !== 16'h0025) begin
            failures++; $display("FAIL game2_clr: got %h/%h expected 0000/0025", if4.score_bcd, if4.high_bcd);
        end
        base = nh_count;
        pulse_inc(4'd9);
        pulse_inc(4'd9);
        asserts++;
        if (if4.score_bcd !== 16'h0018) begin
            failures++; $display("FAIL game2_18: got %h expected 0018", if4.score_bcd);
        end
        pulse_inc(4'd9);
        asserts++;
        if (if4.score_bcd !== 16'h0027 || if4.new_high !== 1'b0) begin
            failures++; $display("FAIL game2_27: got %h/%b expected 0027/0", if4.score_bcd, if4.new_high);
        end
        @(negedge clk);
        asserts++;
        if (if4.new_high !== 1'b1 || if4.high_bcd !== 16'h0027) begin
            failures++; $display("FAIL game2_pulse: got %b/%h expected 1/0027", if4.new_high, if4.high_bcd);
        end
        @(negedge clk);
        asserts++;
        if (if4.new_high !== 1'b0 || nh_count - base !== 1) begin
            failures++; $display("FAIL game2_once: got %b with %0d pulses expected 0 with 1 pulse", if4.new_high, nh_count - base);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_led [4];
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_led = '{7'b0010010, 7'b1001100, 7'h7F, 7'h7F};
        do_reset();
        pulse_inc(4'd9);
        pulse_inc(4'd9);
        pulse_inc(4'd9);
        pulse_inc(4'd9);
        pulse_inc(4'd6);
        asserts++;
        if (if4.score_bcd !== 16'h0042) begin
            failures++; $display("FAIL scan_score: got %h expected 0042", if4.score_bcd);
        end
        wait_digit0_start();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                asserts++;
                if (if4.Anode_Activate !== exp_an[d] || if4.LED_out !== exp_led[d]) begin
                    failures++;
                    $display("FAIL scan_d%0d_c%0d: got %b/%b expected %b/%b", d, c,
                             if4.Anode_Activate, if4.LED_out, exp_an[d], exp_led[d]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_show_high_and_reset();
        do_reset();
        pulse_inc(4'd9);
        pulse_inc(4'd9);
        pulse_clr();
        @(negedge clk);
        asserts++;
        if (if4.score_bcd !== 16'h0000 || if4.high_bcd !== 16'h0018) begin
            failures++; $display("FAIL sh_setup: got %h/%h expected 0000/0018", if4.score_bcd, if4.high_bcd);
        end
        wait_digit0_start();
        asserts++;
        if (if4.LED_out !== 7'b0000001) begin
            failures++; $display("FAIL sh_score_digit: got %b expected 0000001", if4.LED_out);
        end
        if4.show_high = 1'b1;
        @(negedge clk);
        asserts++;
        if (if4.Anode_Activate !== 4'b1110 || if4.LED_out !== 7'b0000000) begin
            failures++; $display("FAIL sh_high_digit: got %b/%b expected 1110/0000000", if4.Anode_Activate, if4.LED_out);
        end
        if4.show_high = 1'b0;
        @(negedge clk);
        asserts++;
        if (if4.LED_out !== 7'b0000001) begin
            failures++; $display("FAIL sh_back: got %b expected 0000001", if4.LED_out);
        end
        reset = 1'b1;
        @(negedge clk);
        asserts++;
        if (if4.Anode_Activate !== 4'b1111 || if4.LED_out !== 7'h7F) begin
            failures++; $display("FAIL midscan_reset_disp: got %b/%b expected 1111/1111111", if4.Anode_Activate, if4.LED_out);
        end
        asserts++;
        if (if4.score_bcd !== 16'h0000 || if4.high_bcd !== 16'h0000) begin
            failures++; $display("FAIL midscan_reset_score: got %h/%h expected 0000/0000", if4.score_bcd, if4.high_bcd);
        end
        reset = 1'b0;
    endtask

    initial begin
        asserts        = 0;
        failures       = 0;
        reset          = 1'b1;
        if4.score_inc  = 1'b0;
        if4.inc_amount = 4'd0;
        if4.score_clr  = 1'b0;
        if4.show_high  = 1'b0;
        if2.score_inc  = 1'b0;
        if2.inc_amount = 4'd0;
        if2.score_clr  = 1'b0;
        if2.show_high  = 1'b0;
        test_reset();
        test_increment();
        test_saturation();
        test_new_high();
        test_scan();
        test_show_high_and_reset();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
